lane_exec: RTL
==============

# lane_exec

Parametrised N-lane execute stage for the VLIW core; the successor to the fixed two-lane execute stage. It sits between register read and the memory/writeback stage. Each cycle it accepts one bundle of `LANES` operations, computes integer ALU results into a one-cycle pipeline register, and dispatches floating-point operations to per-lane FPU units. Unlike its predecessor, it honours FPU-unit backpressure, supports flush, and keeps saturating performance counters.

## Interface
Parameters:
- `LANES`, 2, number of issue lanes; lane 0 is the upper slot (`inst[LANES*32-1 -: 32]`).
- `XLEN`, 32, datapath width; must be ≥ 32.
- `NFU`, 7, FPU unit kinds per lane: fadd, fsub, fmul, fdiv, fsqrt, ftoi, itof (indices 0–6).
- `CNTW`, 32, performance counter width.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, synchronous, active-low.
- `flush` in 1: discard the bundle in flight.
- `interlock` in 1: downstream stall; freezes the stage.
- `in_valid` in 1: a bundle is presented.
- `in_ready` out 1: the bundle is accepted this cycle (combinational).
- `pc` in 32 / `inst` in LANES*32: bundle PC and instruction words.
- `srca`, `srcb`, `srcs` in LANES*XLEN: operands, one slice per lane.
- `e_type` in LANES*4: exec type per lane.
- `rt` in LANES*5 / `rt_flag` in LANES: destination register and write enable.
- `uart_rdata` in 8: UART byte for the In* instructions (lane 0 only).
- `fu_ready` in LANES*NFU: FPU unit can accept an operation.
- `out_valid` out 1; `pc_out` out 32; `inst_out` out LANES*32; `fetch_core` out 4.
- `tdata` out LANES*XLEN; `rt_out` out LANES*5; `rt_flag_out` out LANES.
- `fu_valid` out LANES*NFU: one-cycle dispatch pulse.
- `fu_srca`, `fu_srcb` out LANES*XLEN; `fu_rt` out LANES*5.
- `issue_cnt`, `hold_cnt` out CNTW: performance counters.

## Operation
- Define `need[l][k] = (e_type[l] == EF<k>)`.
- Define `fu_block = OR over l,k of (need[l][k] & ~fu_ready[l][k])`.
- `in_ready = in_valid & ~interlock & ~flush & ~fu_block`. A bundle is accepted atomically: every lane issues, or none does.
- On accept, the stage loads `pc_out`, `inst_out`, `tdata`, `rt_out`, `rt_flag_out`, sets `fetch_core = srca[lane0][3:0]`, and sets `out_valid = 1`.
  - Lanes with FP types get `rt_flag_out = 0`; their writeback is owned by the FPU.
  - `fu_valid[l][k] = need[l][k]`; `fu_srca`, `fu_srcb`, `fu_rt` load for every lane.
- ALU results, by `e_type`:
  - ENop: `srcb`.
  - EAdd / ESub: signed, wrap modulo 2^XLEN.
  - ERshift: arithmetic shift.
  - ELshift: logical shift.
  - Shift amount is `srcb[$clog2(XLEN)-1:0]`; higher bits are ignored.
  - EXor / EAnd: bitwise.
  - Unknown codes: `srcb`.
- In* instructions, lane 0 only: the opcode selects byte b in 0..3 (Inll = 0, Inlh = 1, Inul = 2, Inuh = 3). `tdata = srcs` with byte b replaced by `uart_rdata`. On other lanes, In* opcodes get ALU semantics.
- Rules by priority, highest first:
  - Reset: all outputs 0; `inst_out` = all-Nop encoding; counters 0.
  - `flush`: `out_valid = 0`, `rt_flag_out = 0`, `fu_valid = 0`; other data registers hold; counters unchanged.
  - `interlock`: all registers hold, except that `fu_valid` clears to 0 (no double dispatch). `hold_cnt` does not count.
  - `in_valid & fu_block`: bubble. `out_valid = 0`, `rt_flag_out = 0`, `fu_valid = 0`; `hold_cnt` +1, saturating at 2^CNTW−1.
  - `~in_valid`: bubble, as above, without counting.
  - Accept: `issue_cnt` +1, saturating.

## Timing
- Latency is 1 cycle: a bundle accepted at edge n is visible on outputs after edge n.
- `fu_valid` is high for exactly one cycle per accepted FP operation, with `fu_srca`, `fu_srcb` and `fu_rt` stable during that cycle.
- `fu_ready` is sampled combinationally in the accept cycle.
- `in_ready` depends combinationally on `interlock`, `flush`, `fu_ready` and `e_type`. Upstream must hold the bundle while `in_ready = 0`.
- `fu_ready` dropping mid-hold has no effect beyond extending the hold.
- Reset or flush mid-hold drops the pending bundle's dispatch.
- Back-to-back accepts give full throughput, one bundle per cycle.

## Structure
- Shared `inst_package`:
  - `e_type` enum: ENop, EAdd, ESub, ERshift, ELshift, EXor, EAnd, EFadd, EFsub, EFmul, EFdiv, EFsqrt, EFtoi, EItof.
  - Opcodes Nop, Inll, Inlh, Inul, Inuh.
  - New function `fu_index(e_type)`, returning 0–6, or NFU when the type is not FP.
- Sub-module `lane_alu` (XLEN parameter): purely combinational ALU plus In* byte insert. Instantiated LANES times via generate.
- The top level owns the handshake, output registers, dispatch and counters.
- FPU interfaces are flattened to vectors, so LANES can scale without a fixed set of interface ports.

## Test plan
- Lane 0 EAdd 0x7FFFFFFF+1, lane 1 ERshift 0x80000000 by 33 → next cycle `tdata0 = 0x80000000`, `tdata1 = 0xC0000000`, `out_valid = 1`, `issue_cnt = 1`.
- Lane 1 EFmul with `fu_ready[1][2] = 0` for 3 cycles, then 1:
  - During the hold: `in_ready = 0`, `out_valid = 0`, `hold_cnt = 3`.
  - On release: one `fu_valid[1][2]` pulse, and lane 0's result appears in the same cycle.
- Inlh on lane 0, `srcs = 0x11223344`, `uart_rdata = 0xAB` → `tdata0 = 0x1122AB44`. The same opcode on lane 1 gives the ALU result.
- Accept EFadd, then `interlock = 1` for 2 cycles → `fu_valid` is high for 1 cycle only; `tdata` and `pc_out` hold; no further accept.
- `flush` together with a valid bundle → `out_valid = 0`, no `fu_valid`, `issue_cnt` unchanged. Reset mid-stream → all outputs 0, `inst_out` = Nop bundle.
- `CNTW = 4`, 20 back-to-back accepts → `issue_cnt` saturates at 15. LANES = 4 build: all lanes compute independently.

Source files
------------

// File: rtl/inst_package.sv
// inst_package: exec-type and opcode encodings shared by the execute stage
// Provides e_type_t, the In* opcodes, the all-Nop instruction word and fu_index().
package inst_package;
   typedef enum logic [3:0] {
      ENop, EAdd, ESub, ERshift, ELshift, EXor, EAnd,
      EFadd, EFsub, EFmul, EFdiv, EFsqrt, EFtoi, EItof
   } e_type_t;
   // Opcode lives in inst[31:26]; In* low two bits are the target byte index.
   localparam logic [5:0] Nop  = 6'h00;
   localparam logic [5:0] Inll = 6'h30;
   localparam logic [5:0] Inlh = 6'h31;
   localparam logic [5:0] Inul = 6'h32;
   localparam logic [5:0] Inuh = 6'h33;
   localparam logic [31:0] NOP_INST = {Nop, 26'd0};
   localparam int unsigned NFU_KINDS = 7;
   // FPU unit index 0..6 for FP exec types, NFU_KINDS otherwise.
   function automatic int unsigned fu_index(input logic [3:0] e);
      return (e >= EFadd && e <= EItof) ? 32'(e - EFadd) : NFU_KINDS;
   endfunction
endpackage

// File: rtl/lane_alu.sv
// lane_alu: combinational per-lane integer ALU with UART byte insert for In* ops
// Ports: e_type/opcode select the operation, in_en enables In* (lane 0 only),
// srca/srcb ALU operands, srcs/uart_rdata In* merge inputs, result the lane value.
module lane_alu import inst_package::*; #(
   parameter int XLEN = 32
) (
   input  logic [3:0]      e_type,
   input  logic [5:0]      opcode,
   input  logic            in_en,
   input  logic [XLEN-1:0] srca,
   input  logic [XLEN-1:0] srcb,
   input  logic [XLEN-1:0] srcs,
   input  logic [7:0]      uart_rdata,
   output logic [XLEN-1:0] result
);
   localparam int SW = $clog2(XLEN);
   logic [SW-1:0]   sh;
   logic [XLEN-1:0] alu;
   logic [XLEN-1:0] ins;
   always_comb begin
      sh = srcb[SW-1:0];
      case (e_type)
         EAdd:    alu = srca + srcb;
         ESub:    alu = srca - srcb;
         ERshift: alu = $signed(srca) >>> sh;
         ELshift: alu = srca << sh;
         EXor:    alu = srca ^ srcb;
         EAnd:    alu = srca & srcb;
         default: alu = srcb;
      endcase
      ins = srcs;
      ins[8*opcode[1:0] +: 8] = uart_rdata;
      result = (in_en && opcode inside {Inll, Inlh, Inul, Inuh}) ? ins : alu;
   end
endmodule

// File: rtl/lane_exec.sv
// lane_exec: N-lane execute stage with atomic issue, FPU dispatch and perf counters
// Ports: clk/rstn (sync active-low), flush, interlock, in_valid/in_ready handshake;
// bundle inputs pc/inst/srca/srcb/srcs/e_type/rt/rt_flag/uart_rdata; fu_ready per
// lane and unit. Registered outputs: out_valid, pc_out, inst_out, fetch_core, tdata,
// rt_out, rt_flag_out, fu_valid/fu_srca/fu_srcb/fu_rt dispatch, issue_cnt, hold_cnt.
// Lane 0 is the most significant slice of every flattened vector; within a lane's
// NFU slice, bit k is FPU unit k.
module lane_exec import inst_package::*; #(
   parameter int LANES = 2,
   parameter int XLEN  = 32,
   parameter int NFU   = 7,
   parameter int CNTW  = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  flush,
   input  logic                  interlock,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [31:0]           pc,
   input  logic [LANES*32-1:0]   inst,
   input  logic [LANES*XLEN-1:0] srca,
   input  logic [LANES*XLEN-1:0] srcb,
   input  logic [LANES*XLEN-1:0] srcs,
   input  logic [LANES*4-1:0]    e_type,
   input  logic [LANES*5-1:0]    rt,
   input  logic [LANES-1:0]      rt_flag,
   input  logic [7:0]            uart_rdata,
   input  logic [LANES*NFU-1:0]  fu_ready,
   output logic                  out_valid,
   output logic [31:0]           pc_out,
   output logic [LANES*32-1:0]   inst_out,
   output logic [3:0]            fetch_core,
   output logic [LANES*XLEN-1:0] tdata,
   output logic [LANES*5-1:0]    rt_out,
   output logic [LANES-1:0]      rt_flag_out,
   output logic [LANES*NFU-1:0]  fu_valid,
   output logic [LANES*XLEN-1:0] fu_srca,
   output logic [LANES*XLEN-1:0] fu_srcb,
   output logic [LANES*5-1:0]    fu_rt,
   output logic [CNTW-1:0]       issue_cnt,
   output logic [CNTW-1:0]       hold_cnt
);
   localparam int LW = LANES*XLEN;
   logic [LANES*NFU-1:0] need;
   logic [LANES-1:0]     fp_lane;
   logic [LW-1:0]        alu_res;
   logic                 fu_block;
   logic                 out_valid_q, out_valid_d;
   logic [31:0]          pc_out_q, pc_out_d;
   logic [LANES*32-1:0]  inst_out_q, inst_out_d;
   logic [3:0]           fetch_core_q, fetch_core_d;
   logic [LW-1:0]        tdata_q, tdata_d;
   logic [LANES*5-1:0]   rt_out_q, rt_out_d;
   logic [LANES-1:0]     rt_flag_out_q, rt_flag_out_d;
   logic [LANES*NFU-1:0] fu_valid_q, fu_valid_d;
   logic [LW-1:0]        fu_srca_q, fu_srca_d;
   logic [LW-1:0]        fu_srcb_q, fu_srcb_d;
   logic [LANES*5-1:0]   fu_rt_q, fu_rt_d;
   logic [CNTW-1:0]      issue_cnt_q, issue_cnt_d;
   logic [CNTW-1:0]      hold_cnt_q, hold_cnt_d;

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      localparam int S = LANES - 1 - l;
      lane_alu #(.XLEN(XLEN)) u_alu (
         .e_type     (e_type[S*4 +: 4]),
         .opcode     (inst[S*32+26 +: 6]),
         .in_en      (l == 0),
         .srca       (srca[S*XLEN +: XLEN]),
         .srcb       (srcb[S*XLEN +: XLEN]),
         .srcs       (srcs[S*XLEN +: XLEN]),
         .uart_rdata (uart_rdata),
         .result     (alu_res[S*XLEN +: XLEN])
      );
      for (genvar k = 0; k < NFU; k++) begin : g_fu
         assign need[S*NFU + k] = fu_index(e_type[S*4 +: 4]) == k;
      end
      assign fp_lane[S] = |need[S*NFU +: NFU];
   end

   // Any FP op whose unit is busy blocks the whole bundle (atomic issue).
   assign fu_block = |(need & ~fu_ready);
   assign in_ready = in_valid & ~interlock & ~flush & ~fu_block;

   always_comb begin
      out_valid_d   = out_valid_q;
      pc_out_d      = pc_out_q;
      inst_out_d    = inst_out_q;
      fetch_core_d  = fetch_core_q;
      tdata_d       = tdata_q;
      rt_out_d      = rt_out_q;
      rt_flag_out_d = rt_flag_out_q;
      fu_srca_d     = fu_srca_q;
      fu_srcb_d     = fu_srcb_q;
      fu_rt_d       = fu_rt_q;
      issue_cnt_d   = issue_cnt_q;
      hold_cnt_d    = hold_cnt_q;
      // Dispatch is a single-cycle pulse; anything but an accept clears it.
      fu_valid_d    = in_ready ? need : '0;
      if (flush) begin
         out_valid_d   = 1'b0;
         rt_flag_out_d = '0;
      end else if (!interlock) begin
         out_valid_d   = in_ready;
         rt_flag_out_d = in_ready ? rt_flag & ~fp_lane : '0;
         hold_cnt_d    = (in_valid && !in_ready) ? hold_cnt_q + CNTW'(hold_cnt_q != '1) : hold_cnt_q;
         if (in_ready) begin
            pc_out_d     = pc;
            inst_out_d   = inst;
            fetch_core_d = srca[(LANES-1)*XLEN +: 4];
            tdata_d      = alu_res;
            rt_out_d     = rt;
            fu_srca_d    = srca;
            fu_srcb_d    = srcb;
            fu_rt_d      = rt;
            issue_cnt_d  = issue_cnt_q + CNTW'(issue_cnt_q != '1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         out_valid_q   <= 1'b0;
         pc_out_q      <= '0;
         inst_out_q    <= {LANES{NOP_INST}};
         fetch_core_q  <= '0;
         tdata_q       <= '0;
         rt_out_q      <= '0;
         rt_flag_out_q <= '0;
         fu_valid_q    <= '0;
         fu_srca_q     <= '0;
         fu_srcb_q     <= '0;
         fu_rt_q       <= '0;
         issue_cnt_q   <= '0;
         hold_cnt_q    <= '0;
      end else begin
         out_valid_q   <= out_valid_d;
         pc_out_q      <= pc_out_d;
         inst_out_q    <= inst_out_d;
         fetch_core_q  <= fetch_core_d;
         tdata_q       <= tdata_d;
         rt_out_q      <= rt_out_d;
         rt_flag_out_q <= rt_flag_out_d;
         fu_valid_q    <= fu_valid_d;
         fu_srca_q     <= fu_srca_d;
         fu_srcb_q     <= fu_srcb_d;
         fu_rt_q       <= fu_rt_d;
         issue_cnt_q   <= issue_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
      end
   end

   assign out_valid   = out_valid_q;
   assign pc_out      = pc_out_q;
   assign inst_out    = inst_out_q;
   assign fetch_core  = fetch_core_q;
   assign tdata       = tdata_q;
   assign rt_out      = rt_out_q;
   assign rt_flag_out = rt_flag_out_q;
   assign fu_valid    = fu_valid_q;
   assign fu_srca     = fu_srca_q;
   assign fu_srcb     = fu_srcb_q;
   assign fu_rt       = fu_rt_q;
   assign issue_cnt   = issue_cnt_q;
   assign hold_cnt    = hold_cnt_q;
endmodule
